baccarat_card_datapath: RTL and testbench

//  Datapath responder to the baccarat game controller's load strobes. On each load_* strobe it

---
 rtl/baccarat_card_datapath_if.sv | 29 ++
 rtl/baccarat_card_datapath.sv | 105 ++++++++++
 tb/tb_baccarat_card_datapath.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/baccarat_card_datapath_if.sv
// Controller <-> card datapath bundle: load strobes toward the datapath, ranks and scores back.
interface baccarat_card_datapath_if;
   logic       new_game;
   logic       load_pcard1, load_pcard2, load_pcard3;
   logic       load_dcard1, load_dcard2, load_dcard3;
   logic [3:0] pcard1_rank, pcard2_rank, pcard3_rank;
   logic [3:0] dcard1_rank, dcard2_rank, dcard3_rank;
   logic [3:0] pscore;
   logic [3:0] dscore;
   logic [3:0] pcard3;
   logic [2:0] cards_dealt;
   logic       protocol_err;

   modport master (
      output new_game, load_pcard1, load_pcard2, load_pcard3,
             load_dcard1, load_dcard2, load_dcard3,
      input  pcard1_rank, pcard2_rank, pcard3_rank,
             dcard1_rank, dcard2_rank, dcard3_rank,
             pscore, dscore, pcard3, cards_dealt, protocol_err
   );

   modport slave (
      input  new_game, load_pcard1, load_pcard2, load_pcard3,
             load_dcard1, load_dcard2, load_dcard3,
      output pcard1_rank, pcard2_rank, pcard3_rank,
             dcard1_rank, dcard2_rank, dcard3_rank,
             pscore, dscore, pcard3, cards_dealt, protocol_err
   );
endinterface

// File: rtl/baccarat_card_datapath.sv
// Baccarat card datapath: draws cards from an LFSR deck into six hand slots and scores both hands.
// Optional FORCED_CARD_EN adds force_card/force_value to override the drawn rank.
module baccarat_card_datapath #(
   parameter logic [7:0] SEED = 8'h01
) (
   input  logic                      slow_clock,
   input  logic                      resetb,
`ifdef FORCED_CARD_EN
   input  logic                      force_card,
   input  logic [3:0]                force_value,
`endif
   baccarat_card_datapath_if.slave   bus
);
   localparam int unsigned NSLOT   = 6;
   localparam int unsigned RANK_W  = 4;
   localparam int unsigned LFSR_W  = 8;
   localparam logic [7:0]  LFSR_INIT = (SEED == 8'h00) ? 8'h01 : SEED;

   logic [LFSR_W-1:0]             lfsr;
   logic [NSLOT-1:0][RANK_W-1:0]  rank;
   logic [2:0]                    cards_dealt;
   logic                          protocol_err;

   logic [NSLOT-1:0]  load_vec;
   logic [NSLOT-1:0]  grant;
   logic [NSLOT-1:0]  filled;
   logic              multi_load;
   logic              grant_empty;
   logic [LFSR_W-1:0] lfsr_mod;
   logic [RANK_W-1:0] lfsr_rank;
   logic [RANK_W-1:0] draw_rank;

   // Bit 0 is the highest-priority slot (pcard1) so lowest-set-bit isolation implements priority.
   assign load_vec    = {bus.load_dcard3, bus.load_dcard2, bus.load_dcard1,
                         bus.load_pcard3, bus.load_pcard2, bus.load_pcard1};
   assign grant       = load_vec & NSLOT'(~load_vec + NSLOT'(1));
   assign multi_load  = (load_vec & NSLOT'(load_vec - NSLOT'(1))) != '0;

   always_comb begin
      filled = '0;
      for (int i = 0; i < NSLOT; i++) filled[i] = (rank[i] != '0);
   end
   assign grant_empty = (grant & ~filled) != '0;

   assign lfsr_mod  = lfsr % LFSR_W'(13);
   assign lfsr_rank = RANK_W'(lfsr_mod) + RANK_W'(1);

`ifdef FORCED_CARD_EN
   always_comb begin
      draw_rank = lfsr_rank;
      if (force_card) begin
         if (force_value == '0 || force_value > RANK_W'(13)) draw_rank = RANK_W'(13);
         else                                                 draw_rank = force_value;
      end
   end
`else
   assign draw_rank = lfsr_rank;
`endif

   // Deck advances every edge; slots and counters follow the strobes.
   always_ff @(posedge slow_clock or negedge resetb) begin
      if (!resetb) begin
         lfsr         <= LFSR_INIT;
         rank         <= '0;
         cards_dealt  <= '0;
         protocol_err <= 1'b0;
      end else begin
         lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
         if (multi_load) protocol_err <= 1'b1;
         if (bus.new_game) begin
            rank        <= '0;
            cards_dealt <= '0;
         end else if (grant != '0) begin
            for (int i = 0; i < NSLOT; i++)
               if (grant[i]) rank[i] <= draw_rank;
            if (grant_empty && cards_dealt < 3'(NSLOT))
               cards_dealt <= cards_dealt + 3'(1);
         end
      end
   end

   function automatic logic [RANK_W-1:0] card_value(input logic [RANK_W-1:0] r);
      return (r <= RANK_W'(9)) ? r : '0;
   endfunction

   function automatic logic [3:0] hand_score(input logic [RANK_W-1:0] a, b, c);
      logic [4:0] sum;
      sum = 5'(card_value(a)) + 5'(card_value(b)) + 5'(card_value(c));
      if (sum >= 5'd20)      sum = sum - 5'd20;
      else if (sum >= 5'd10) sum = sum - 5'd10;
      return 4'(sum);
   endfunction

   assign bus.pcard1_rank  = rank[0];
   assign bus.pcard2_rank  = rank[1];
   assign bus.pcard3_rank  = rank[2];
   assign bus.dcard1_rank  = rank[3];
   assign bus.dcard2_rank  = rank[4];
   assign bus.dcard3_rank  = rank[5];
   assign bus.pscore       = hand_score(rank[0], rank[1], rank[2]);
   assign bus.dscore       = hand_score(rank[3], rank[4], rank[5]);
   assign bus.pcard3       = card_value(rank[2]);
   assign bus.cards_dealt  = cards_dealt;
   assign bus.protocol_err = protocol_err;
endmodule

// File: tb/tb_baccarat_card_datapath.sv
// Directed bench for baccarat_card_datapath; LFSR sequence from SEED 01 is
// 01,02,04,08,11,23,47,8E,1C,38 -> ranks 2,3,5,9,5,10,7,13,3,5 at edges 1..10 after reset.
module tb_baccarat_card_datapath;
   logic slow_clock = 1'b0;
   logic resetb     = 1'b0;
   int   n_cmp = 0;
   int   n_err = 0;
`ifdef FORCED_CARD_EN
   logic       force_card  = 1'b0;
   logic [3:0] force_value = 4'd0;
`endif

   baccarat_card_datapath_if bus ();

   baccarat_card_datapath #(.SEED(8'h01)) dut (
      .slow_clock (slow_clock),
      .resetb     (resetb),
`ifdef FORCED_CARD_EN
      .force_card (force_card),
      .force_value(force_value),
`endif
      .bus        (bus)
   );

   always #5 slow_clock = ~slow_clock;

   task automatic clear_strobes();
      bus.new_game    = 1'b0;
      bus.load_pcard1 = 1'b0; bus.load_pcard2 = 1'b0; bus.load_pcard3 = 1'b0;
      bus.load_dcard1 = 1'b0; bus.load_dcard2 = 1'b0; bus.load_dcard3 = 1'b0;
   endtask

   // One rising edge; strobes are dropped and outputs sampled 1 time unit later.
   task automatic tick();
      @(posedge slow_clock);
      #1;
      clear_strobes();
   endtask

   // Release lands mid-cycle so the next rising edge is edge 1 with lfsr=01.
   task automatic do_reset();
      clear_strobes();
      @(posedge slow_clock);
      #1 resetb = 1'b0;
      #3 resetb = 1'b1;
   endtask

   task automatic test_reset();
      clear_strobes();
      #2;
      n_cmp++; if (bus.pcard1_rank !== 4'd0) begin n_err++; $display("FAIL rst_pcard1: got %0d expected 0", bus.pcard1_rank); end
      n_cmp++; if (bus.dcard3_rank !== 4'd0) begin n_err++; $display("FAIL rst_dcard3: got %0d expected 0", bus.dcard3_rank); end
      n_cmp++; if (bus.cards_dealt !== 3'd0) begin n_err++; $display("FAIL rst_cards: got %0d expected 0", bus.cards_dealt); end
      n_cmp++; if (bus.protocol_err !== 1'b0) begin n_err++; $display("FAIL rst_perr: got %0d expected 0", bus.protocol_err); end
      do_reset();
   endtask

   task automatic test_protocol();
      do_reset();
      bus.load_pcard2 = 1'b1; bus.load_dcard2 = 1'b1; tick();             // edge1: rank 2
      n_cmp++; if (bus.pcard2_rank !== 4'd2) begin n_err++; $display("FAIL perr_pcard2: got %0d expected 2", bus.pcard2_rank); end
      n_cmp++; if (bus.dcard2_rank !== 4'd0) begin n_err++; $display("FAIL perr_dcard2: got %0d expected 0", bus.dcard2_rank); end
      n_cmp++; if (bus.protocol_err !== 1'b1) begin n_err++; $display("FAIL perr_set: got %0d expected 1", bus.protocol_err); end
      n_cmp++; if (bus.cards_dealt !== 3'd1) begin n_err++; $display("FAIL perr_cards: got %0d expected 1", bus.cards_dealt); end
      bus.new_game = 1'b1; bus.load_pcard1 = 1'b1; tick();                 // edge2: cleared
      n_cmp++; if (bus.pcard1_rank !== 4'd0) begin n_err++; $display("FAIL ng_pcard1: got %0d expected 0", bus.pcard1_rank); end
      n_cmp++; if (bus.pcard2_rank !== 4'd0) begin n_err++; $display("FAIL ng_pcard2: got %0d expected 0", bus.pcard2_rank); end
      n_cmp++; if (bus.cards_dealt !== 3'd0) begin n_err++; $display("FAIL ng_cards: got %0d expected 0", bus.cards_dealt); end
      n_cmp++; if (bus.protocol_err !== 1'b1) begin n_err++; $display("FAIL ng_perr_hold: got %0d expected 1", bus.protocol_err); end
      bus.load_dcard1 = 1'b1; tick();                                     // edge3: rank 5
      n_cmp++; if (bus.dcard1_rank !== 4'd5) begin n_err++; $display("FAIL pri_dcard1: got %0d expected 5", bus.dcard1_rank); end
      bus.load_dcard2 = 1'b1; bus.load_dcard3 = 1'b1; tick();             // edge4: rank 9 to dcard2
      n_cmp++; if (bus.dcard2_rank !== 4'd9) begin n_err++; $display("FAIL pri_dcard2: got %0d expected 9", bus.dcard2_rank); end
      n_cmp++; if (bus.dcard3_rank !== 4'd0) begin n_err++; $display("FAIL pri_dcard3: got %0d expected 0", bus.dcard3_rank); end
      n_cmp++; if (bus.dscore !== 4'd4) begin n_err++; $display("FAIL pri_dscore: got %0d expected 4", bus.dscore); end
      n_cmp++; if (bus.cards_dealt !== 3'd2) begin n_err++; $display("FAIL pri_cards: got %0d expected 2", bus.cards_dealt); end
   endtask

   // Reset asserted mid-hand must clear state with no clock edge.
   task automatic test_reset_midhand();
      @(posedge slow_clock);
      #1 resetb = 1'b0;
      #2;
      n_cmp++; if (bus.dcard1_rank !== 4'd0) begin n_err++; $display("FAIL mid_dcard1: got %0d expected 0", bus.dcard1_rank); end
      n_cmp++; if (bus.dcard2_rank !== 4'd0) begin n_err++; $display("FAIL mid_dcard2: got %0d expected 0", bus.dcard2_rank); end
      n_cmp++; if (bus.dscore !== 4'd0) begin n_err++; $display("FAIL mid_dscore: got %0d expected 0", bus.dscore); end
      n_cmp++; if (bus.cards_dealt !== 3'd0) begin n_err++; $display("FAIL mid_cards: got %0d expected 0", bus.cards_dealt); end
      n_cmp++; if (bus.protocol_err !== 1'b0) begin n_err++; $display("FAIL mid_perr: got %0d expected 0", bus.protocol_err); end
      resetb = 1'b1;
   endtask

   task automatic test_lfsr_hand();
      do_reset();
      bus.load_pcard1 = 1'b1; tick();                                     // edge1: 2
      n_cmp++; if (bus.pcard1_rank !== 4'd2) begin n_err++; $display("FAIL lfsr_pcard1: got %0d expected 2", bus.pcard1_rank); end
      n_cmp++; if (bus.pscore !== 4'd2) begin n_err++; $display("FAIL lfsr_pscore1: got %0d expected 2", bus.pscore); end
      bus.load_dcard1 = 1'b1; tick();                                     // edge2: 3
      n_cmp++; if (bus.dcard1_rank !== 4'd3) begin n_err++; $display("FAIL lfsr_dcard1: got %0d expected 3", bus.dcard1_rank); end
      bus.load_pcard2 = 1'b1; tick();                                     // edge3: 5
      bus.load_pcard3 = 1'b1; tick();                                     // edge4: 9
      n_cmp++; if (bus.pscore !== 4'd6) begin n_err++; $display("FAIL lfsr_pscore3: got %0d expected 6", bus.pscore); end
      n_cmp++; if (bus.pcard3 !== 4'd9) begin n_err++; $display("FAIL lfsr_pcard3: got %0d expected 9", bus.pcard3); end
      bus.load_dcard2 = 1'b1; tick();                                     // edge5: 5
      bus.load_dcard3 = 1'b1; tick();                                     // edge6: 10
      n_cmp++; if (bus.dcard3_rank !== 4'd10) begin n_err++; $display("FAIL lfsr_dcard3: got %0d expected 10", bus.dcard3_rank); end
      n_cmp++; if (bus.dscore !== 4'd8) begin n_err++; $display("FAIL lfsr_dscore: got %0d expected 8", bus.dscore); end
      n_cmp++; if (bus.cards_dealt !== 3'd6) begin n_err++; $display("FAIL full_cards: got %0d expected 6", bus.cards_dealt); end
      bus.load_pcard1 = 1'b1; tick();                                     // edge7: reload 7
      n_cmp++; if (bus.pcard1_rank !== 4'd7) begin n_err++; $display("FAIL reload_pcard1: got %0d expected 7", bus.pcard1_rank); end
      n_cmp++; if (bus.pscore !== 4'd1) begin n_err++; $display("FAIL reload_pscore: got %0d expected 1", bus.pscore); end
      n_cmp++; if (bus.cards_dealt !== 3'd6) begin n_err++; $display("FAIL sat_cards: got %0d expected 6", bus.cards_dealt); end
   endtask

   // LFSR must advance on idle edges; edge8 draws a king.
   task automatic test_free_run();
      do_reset();
      repeat (7) tick();
      bus.load_pcard3 = 1'b1; tick();                                     // edge8: 13
      n_cmp++; if (bus.pcard3_rank !== 4'd13) begin n_err++; $display("FAIL free_pcard3_rank: got %0d expected 13", bus.pcard3_rank); end
      n_cmp++; if (bus.pcard3 !== 4'd0) begin n_err++; $display("FAIL free_pcard3_val: got %0d expected 0", bus.pcard3); end
      n_cmp++; if (bus.pscore !== 4'd0) begin n_err++; $display("FAIL free_pscore0: got %0d expected 0", bus.pscore); end
      bus.load_pcard1 = 1'b1; tick();                                     // edge9: 3
      n_cmp++; if (bus.pcard1_rank !== 4'd3) begin n_err++; $display("FAIL free_pcard1: got %0d expected 3", bus.pcard1_rank); end
      n_cmp++; if (bus.cards_dealt !== 3'd2) begin n_err++; $display("FAIL free_cards: got %0d expected 2", bus.cards_dealt); end
   endtask

`ifdef FORCED_CARD_EN
   task automatic test_forced();
      do_reset();
      force_card = 1'b1;
      force_value = 4'd7;  bus.load_pcard1 = 1'b1; tick();
      force_value = 4'd8;  bus.load_pcard2 = 1'b1; tick();
      n_cmp++; if (bus.pscore !== 4'd5) begin n_err++; $display("FAIL frc_pscore2: got %0d expected 5", bus.pscore); end
      force_value = 4'd9;  bus.load_pcard3 = 1'b1; tick();
      n_cmp++; if (bus.pscore !== 4'd4) begin n_err++; $display("FAIL frc_pscore3: got %0d expected 4", bus.pscore); end
      n_cmp++; if (bus.pcard3 !== 4'd9) begin n_err++; $display("FAIL frc_pcard3: got %0d expected 9", bus.pcard3); end
      force_value = 4'd13; bus.load_dcard1 = 1'b1; tick();
      force_value = 4'd10; bus.load_dcard2 = 1'b1; tick();
      force_value = 4'd1;  bus.load_dcard3 = 1'b1; tick();
      n_cmp++; if (bus.dscore !== 4'd1) begin n_err++; $display("FAIL frc_dscore: got %0d expected 1", bus.dscore); end
      force_value = 4'd12; bus.load_pcard3 = 1'b1; tick();
      n_cmp++; if (bus.pcard3 !== 4'd0) begin n_err++; $display("FAIL frc_queen: got %0d expected 0", bus.pcard3); end
      force_value = 4'd0;  bus.load_pcard1 = 1'b1; tick();
      n_cmp++; if (bus.pcard1_rank !== 4'd13) begin n_err++; $display("FAIL frc_clamp0: got %0d expected 13", bus.pcard1_rank); end
      force_value = 4'd15; bus.load_pcard2 = 1'b1; tick();
      n_cmp++; if (bus.pcard2_rank !== 4'd13) begin n_err++; $display("FAIL frc_clamp15: got %0d expected 13", bus.pcard2_rank); end
      force_value = 4'd6; bus.load_pcard2 = 1'b1; bus.load_dcard2 = 1'b1; tick();
      n_cmp++; if (bus.pcard2_rank !== 4'd6) begin n_err++; $display("FAIL frc_perr_p2: got %0d expected 6", bus.pcard2_rank); end
      n_cmp++; if (bus.dcard2_rank !== 4'd10) begin n_err++; $display("FAIL frc_perr_d2: got %0d expected 10", bus.dcard2_rank); end
      n_cmp++; if (bus.protocol_err !== 1'b1) begin n_err++; $display("FAIL frc_perr: got %0d expected 1", bus.protocol_err); end
      force_card = 1'b0;
   endtask
`endif

   initial begin
      test_reset();
      test_protocol();
      test_reset_midhand();
      test_lfsr_hand();
      test_free_run();
`ifdef FORCED_CARD_EN
      test_forced();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
